cpu_controller: RTL and testbench

//  Multi-cycle sequencer for the 16-bit CR16-style datapath. Fetches an instruction, holds it in an

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/cpu_controller_cond_eval.sv | 32 +++
 rtl/cpu_controller.sv | 160 ++++++++++++++++
 tb/tb_cpu_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the CR16-style sequencer
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  // Major opcodes (IR[15:12]); immediate ops reuse the R-type ext code as op
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_SPEC  = 4'h4;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_LUI   = 4'hF;

  // ALU codes shared between R-type ext and immediate op fields
  localparam logic [3:0] ALU_CMP  = 4'hB;
  localparam logic [3:0] ALU_MOV  = 4'hD;

  // Extended codes under OP_SPEC (IR[7:4])
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_HI = 4'h4, C_LS = 4'h5, C_GT = 4'h6, C_LE = 4'h7,
    C_FS = 4'h8, C_FC = 4'h9, C_LO = 4'hA, C_HS = 4'hB,
    C_LT = 4'hC, C_GE = 4'hD, C_UC = 4'hE, C_NV = 4'hF
  } cond_e;

  // ALU operation codes that exist both as R-type ext and as immediate op
  function automatic logic is_alu_code(input logic [3:0] code);
    return code inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7,
                        4'h9, 4'hA, 4'hB, 4'hD, 4'hE};
  endfunction

endpackage

// File: rtl/cpu_controller_cond_eval.sv
// rtl/cpu_controller_cond_eval.sv - branch/jump condition evaluator
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  logic c_f, l_f, f_f, z_f, n_f;
  logic base;

  assign {c_f, l_f, f_f, z_f, n_f} = flags;

  // Conditions come in complementary pairs: the odd code negates the even one
  always_comb begin
    base = 1'b0;
    case (cond[3:1])
      3'd0: base = z_f;
      3'd1: base = c_f;
      3'd2: base = l_f;
      3'd3: base = n_f;
      3'd4: base = f_f;
      3'd5: base = !l_f && !z_f;
      3'd6: base = !n_f && !z_f;
      3'd7: base = 1'b1;
      default: base = 1'b0;
    endcase
    taken = base ^ cond[0];
  end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IMM_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instr,
  input  logic                mem_ready,
  input  logic [4:0]          flags,
  output logic                ir_load,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic [NUM_REGS-1:0] wEnable,
  output logic [1:0]          wb_sel,
  output logic [7:0]          opcode,
  output logic [3:0]          Rdest,
  output logic [3:0]          Rsrc_Imm,
  output logic                Imm_select,
  output logic [IMM_W-1:0]    Imm_in,
  output logic                flags_we,
  output logic                halted
);

  state_e      state, state_nxt;
  logic [15:0] ir;

  logic [3:0] op, ext, alu_code;
  logic       is_rtype, is_imm, is_alu;
  logic       is_load, is_stor, is_jal, is_jcond, is_bcond;
  logic       alu_write, alu_flags;
  logic       taken;
  logic [NUM_REGS-1:0] dest_onehot;

  assign op       = ir[15:12];
  assign ext      = ir[7:4];
  assign opcode   = {op, ext};
  assign Rdest    = ir[11:8];
  assign Rsrc_Imm = ir[3:0];

  assign is_rtype = (op == OP_RTYPE) && is_alu_code(ext);
  assign is_imm   = is_alu_code(op) || (op == OP_LUI);
  assign is_alu   = is_rtype || is_imm;
  assign alu_code = is_rtype ? ext : op;
  assign is_load  = (op == OP_SPEC) && (ext == EXT_LOAD);
  assign is_stor  = (op == OP_SPEC) && (ext == EXT_STOR);
  assign is_jal   = (op == OP_SPEC) && (ext == EXT_JAL);
  assign is_jcond = (op == OP_SPEC) && (ext == EXT_JCOND);
  assign is_bcond = (op == OP_BCOND);

  // Compares only touch the PSR; moves and LUI only touch the register file
  assign alu_write = is_alu && (alu_code != ALU_CMP);
  assign alu_flags = is_alu && (alu_code != ALU_MOV) && (alu_code != OP_LUI);

  assign dest_onehot = NUM_REGS'(1) << Rdest;
  assign Imm_select  = is_imm;

  cond_eval u_cond_eval (
    .cond  (ir[11:8]),
    .flags (flags),
    .taken (taken)
  );

  // Immediate extension: logical ops zero-extend, LUI shifts into the high byte
  always_comb begin
    Imm_in = IMM_W'($signed(ir[7:0]));
    if (op inside {OP_ANDI, OP_ORI, OP_XORI})
      Imm_in = IMM_W'(ir[7:0]);
    else if (op == OP_LUI)
      Imm_in = IMM_W'({ir[7:0], 8'h00});
  end

  // State and instruction register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (ir_load)
        ir <= instr;
    end
  end

  // Next-state and control outputs; FETCH strobes are masked while reset is low
  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 2'd0;
    wEnable   = '0;
    wb_sel    = 2'd0;
    flags_we  = 1'b0;
    halted    = 1'b0;
    case (state)
      FETCH: begin
        mem_req = reset;
        ir_load = reset && mem_ready;
        if (mem_ready)
          state_nxt = DECODE;
      end
      DECODE: begin
        if (ir == 16'h0000)
          state_nxt = HALT;
        else if (is_load || is_stor)
          state_nxt = MEM;
        else
          state_nxt = EXEC;
      end
      EXEC: begin
        pc_en     = 1'b1;
        state_nxt = FETCH;
        if (is_alu) begin
          wEnable  = alu_write ? dest_onehot : '0;
          flags_we = alu_flags;
        end else if (is_bcond) begin
          pc_sel = taken ? 2'd1 : 2'd0;
        end else if (is_jcond) begin
          pc_sel = taken ? 2'd2 : 2'd0;
        end else if (is_jal) begin
          wEnable = dest_onehot;
          wb_sel  = 2'd2;
          pc_sel  = 2'd2;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_stor;
        if (mem_ready) begin
          if (is_load) begin
            state_nxt = WB;
          end else begin
            pc_en     = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      WB: begin
        wEnable   = dest_onehot;
        wb_sel    = 2'd1;
        pc_en     = 1'b1;
        state_nxt = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard bench for cpu_controller
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        mem_ready;
  logic [4:0]  flags;
  logic        ir_load, mem_req, mem_we, addr_sel, pc_en;
  logic [1:0]  pc_sel, wb_sel;
  logic [15:0] wEnable;
  logic [7:0]  opcode;
  logic [3:0]  Rdest, Rsrc_Imm;
  logic        Imm_select;
  logic [15:0] Imm_in;
  logic        flags_we, halted;

  cpu_controller dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .flags(flags),
    .ir_load(ir_load), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .pc_en(pc_en), .pc_sel(pc_sel), .wEnable(wEnable), .wb_sel(wb_sel),
    .opcode(opcode), .Rdest(Rdest), .Rsrc_Imm(Rsrc_Imm), .Imm_select(Imm_select),
    .Imm_in(Imm_in), .flags_we(flags_we), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic        halt;
    logic [15:0] wen;
    logic [1:0]  wb;
    logic [1:0]  psel;
    logic        fwe;
    logic        mwe;
    int          lat;
    logic [15:0] imm;
    logic        isel;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", total, errors);
    $finish;
  endtask

  // Condition table written out entry by entry
  function automatic logic cond_ref(input logic [3:0] c, input logic [4:0] f);
    logic cf, lf, ff, zf, nf;
    {cf, lf, ff, zf, nf} = f;
    case (c)
      4'h0: return zf;
      4'h1: return !zf;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return lf;
      4'h5: return !lf;
      4'h6: return nf;
      4'h7: return !nf;
      4'h8: return ff;
      4'h9: return !ff;
      4'hA: return !lf && !zf;
      4'hB: return lf || zf;
      4'hC: return !nf && !zf;
      4'hD: return nf || zf;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected retirement for one instruction; lat counts cycles after the IR load
  function automatic exp_t model(input logic [15:0] ins, input logic [4:0] f, input int dm);
    exp_t e;
    logic [3:0] op, rd, ext, code;
    logic [7:0] lo;
    op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; lo = ins[7:0];
    e.ins = ins; e.halt = 0; e.wen = 0; e.wb = 0; e.psel = 0; e.fwe = 0; e.mwe = 0; e.lat = 2;
    if (op inside {4'h1, 4'h2, 4'h3}) e.imm = {8'h00, lo};
    else if (op == 4'hF)              e.imm = {lo, 8'h00};
    else                              e.imm = {{8{lo[7]}}, lo};
    e.isel = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF};
    if (ins == 16'h0000) begin
      e.halt = 1;
    end else if ((op == 4'h0 && ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE})
                 || e.isel) begin
      code = (op == 4'h0) ? ext : op;
      if (code == 4'hB) e.fwe = 1;
      else if (code inside {4'hD, 4'hF}) e.wen = 16'h1 << rd;
      else begin e.wen = 16'h1 << rd; e.fwe = 1; end
    end else if (op == 4'h4 && ext == 4'h0) begin
      e.wen = 16'h1 << rd; e.wb = 1; e.lat = 3 + dm;
    end else if (op == 4'h4 && ext == 4'h4) begin
      e.mwe = 1; e.lat = 2 + dm;
    end else if (op == 4'h4 && ext == 4'h8) begin
      e.wen = 16'h1 << rd; e.wb = 2; e.psel = 2;
    end else if (op == 4'h4 && ext == 4'hC) begin
      e.psel = cond_ref(rd, f) ? 2'd2 : 2'd0;
    end else if (op == 4'hC) begin
      e.psel = cond_ref(rd, f) ? 2'd1 : 2'd0;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever an instruction retires or the core halts
  exp_t mon_e;
  bit   mon_active = 0, halt_seen = 0;
  int   mon_cyc = 0;
  always @(negedge clk) begin
    if (!reset) begin
      mon_active = 0;
      halt_seen  = 0;
    end else begin
      if (ir_load) begin mon_active = 1; mon_cyc = 0; end
      else if (mon_active) mon_cyc++;
      chk("wen_onehot0", 32'($onehot0(wEnable)), 32'd1);
      if (pc_en || (halted && !halt_seen)) begin
        if (halted) halt_seen = 1;
        if (q.size() == 0) begin
          chk("unexpected_retire", 32'(q.size()), 32'd1);
        end else begin
          mon_e = q.pop_front();
          chk($sformatf("halted[%h]", mon_e.ins), 32'(halted), 32'(mon_e.halt));
          chk($sformatf("wEnable[%h]", mon_e.ins), 32'(wEnable), 32'(mon_e.wen));
          chk($sformatf("wb_sel[%h]", mon_e.ins), 32'(wb_sel), 32'(mon_e.wb));
          chk($sformatf("pc_sel[%h]", mon_e.ins), 32'(pc_sel), 32'(mon_e.psel));
          chk($sformatf("flags_we[%h]", mon_e.ins), 32'(flags_we), 32'(mon_e.fwe));
          chk($sformatf("mem_we[%h]", mon_e.ins), 32'(mem_we), 32'(mon_e.mwe));
          chk($sformatf("latency[%h]", mon_e.ins), 32'(mon_cyc), 32'(mon_e.lat));
          chk($sformatf("opcode[%h]", mon_e.ins), 32'(opcode), 32'({mon_e.ins[15:12], mon_e.ins[7:4]}));
          chk($sformatf("Rdest[%h]", mon_e.ins), 32'(Rdest), 32'(mon_e.ins[11:8]));
          chk($sformatf("Rsrc_Imm[%h]", mon_e.ins), 32'(Rsrc_Imm), 32'(mon_e.ins[3:0]));
          chk($sformatf("Imm_in[%h]", mon_e.ins), 32'(Imm_in), 32'(mon_e.imm));
          chk($sformatf("Imm_select[%h]", mon_e.ins), 32'(Imm_select), 32'(mon_e.isel));
        end
        mon_active = 0;
      end
    end
  end

  task automatic wait_for(input logic want_addr, input string name);
    int n = 0;
    while (!(mem_req && addr_sel == want_addr)) begin
      @(posedge clk); #1;
      n++;
      if (n > 20) begin
        chk({name, "_timeout"}, 32'(n), 32'd20);
        finish_run();
      end
    end
  endtask

  task automatic mem_pulse(input logic [15:0] data, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    mem_ready = 1'b1;
    instr     = data;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    instr     = 16'($urandom);
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [4:0] f, input int df, input int dm);
    wait_for(1'b0, "fetch");
    flags = f;
    q.push_back(model(ins, f, dm));
    mem_pulse(ins, df);
    if (ins[15:12] == 4'h4 && (ins[7:4] == 4'h0 || ins[7:4] == 4'h4)) begin
      wait_for(1'b1, "mem");
      mem_pulse(16'($urandom), dm);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    logic [3:0]  a, b, c;
    r = 16'($urandom); a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
    case ($urandom_range(0, 8))
      0: r = {4'h0, a, b, c};
      1: r = {b, a, r[7:0]};
      2: r = {4'h4, a, 4'h0, c};
      3: r = {4'h4, a, 4'h4, c};
      4: r = {4'hC, a, r[7:0]};
      5: r = {4'h4, a, 4'hC, c};
      6: r = {4'h4, a, 4'h8, c};
      default: ;
    endcase
    if (r == 16'h0000) r = 16'h0001;
    return r;
  endfunction

  initial begin
    reset = 1'b0; mem_ready = 1'b0; instr = 16'h0000; flags = 5'h00;
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wEnable", 32'(wEnable), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_Imm_in", 32'(Imm_in), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    run_instr(16'h0355, 5'h00, 0, 0);
    run_instr(16'h11FF, 5'h00, 1, 0);
    run_instr(16'h51FF, 5'h00, 0, 0);
    run_instr(16'h4207, 5'h00, 0, 3);
    run_instr(16'hC0FE, 5'b00010, 0, 0);
    run_instr(16'hC0FE, 5'b00000, 0, 0);
    run_instr(16'h4E89, 5'h00, 2, 0);
    run_instr(16'h4347, 5'h00, 0, 1);
    run_instr(16'hF2AB, 5'h00, 0, 0);
    run_instr(16'h0B13, 5'h00, 0, 0);

    for (int i = 0; i < 300; i++)
      run_instr(rand_instr(), 5'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));

    // Reset in the middle of a load: everything drops at once, then FETCH
    wait_for(1'b0, "fetch");
    q.push_back(model(16'h4207, 5'h00, 0));
    mem_pulse(16'h4207, 0);
    wait_for(1'b1, "mem");
    reset = 1'b0;
    q.delete();
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_addr_sel", 32'(addr_sel), 32'd0);
    chk("abort_wEnable", 32'(wEnable), 32'd0);
    chk("abort_pc_en", 32'(pc_en), 32'd0);
    chk("abort_opcode", 32'(opcode), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("post_rst_mem_req", 32'(mem_req), 32'd1);
    chk("post_rst_addr_sel", 32'(addr_sel), 32'd0);

    run_instr(16'h0355, 5'h00, 0, 0);
    run_instr(16'h0000, 5'h00, 0, 0);
    repeat (6) begin @(posedge clk); #1; end
    chk("halt_sticky", 32'(halted), 32'd1);
    mem_ready = 1'b1; instr = 16'h0355;
    repeat (3) begin @(posedge clk); #1; end
    chk("halt_absorb", 32'(halted), 32'd1);
    chk("halt_mem_req", 32'(mem_req), 32'd0);
    chk("halt_pc_en", 32'(pc_en), 32'd0);
    chk("halt_wEnable", 32'(wEnable), 32'd0);
    mem_ready = 1'b0;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    finish_run();
  end

  initial begin
    #500000;
    chk("global_timeout", 32'd1, 32'd0);
    finish_run();
  end

endmodule
